pe_array_wrapper: RTL and testbench
===================================

Name:
pe_array_wrapper

Overview:
- Weight-stationary KERNEL_SIZE x KERNEL_SIZE array of multiply-accumulate processing elements (PEs), used as the convolution core of the map-inflation datapath.
- Loads a KxK weight matrix after reset, then accepts one K-element data vector per enabled cycle.
- Produces K row dot-products with one cycle of skew per row, plus a result-valid strobe.

Parameters:
- KERNEL_SIZE, 3, array dimension K (rows = columns = K); must be >= 1.
- DATA_WIDTH, 8, bits per data element.
- WEIGHT_WIDTH, 8, bits per weight.
- Derived (localparam): PRODUCT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH; SUM_WIDTH = PRODUCT_WIDTH + KERNEL_SIZE.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  input-valid qualifier; dataIn is accepted on a rising edge when en=1 and ready=1.
- dataIn  in  DATA_WIDTH*K  element c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- weightsIn  in  WEIGHT_WIDTH*K*K  W[r][c] at bits [(r*K+c)*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- dataOut  out  SUM_WIDTH*K  row r result at bits [r*SUM_WIDTH +: SUM_WIDTH].
- dataOut_done  out  1  high while at least one dataOut lane holds a valid result.
- ready  out  1  high once weights are loaded and the array accepts data.

Behaviour:
- Reset (rstn=0, asynchronous): all weight, pipeline, valid and sum registers cleared; FSM = LOAD with row counter 0; ready=0, dataOut_done=0, dataOut=0.
- FSM LOAD: one weight row per clock.
  - At each rising edge, weight row r_cnt (K weights) is copied from weightsIn into the PE row r_cnt, and r_cnt increments.
  - After row K-1 is captured, the FSM moves to RUN.
  - ready rises after the edge that loads the last row, i.e. K cycles after reset release.
- FSM RUN: ready=1 and stays high. Weights are frozen until the next reset; later changes on weightsIn are ignored.
- en while in LOAD is ignored; no data is accepted.
- Data skew chain (RUN state):
  - Registers d[0..K-1] (each a K-element vector) with valid bits v[0..K-1].
  - Each edge: d[0] <= dataIn and v[0] <= en.
  - For r >= 1: d[r] <= d[r-1] and v[r] <= v[r-1].
- Row MAC: each edge, s[r] <= sum over c of W[r][c]*d[r][c] and sv[r] <= v[r].
- Arithmetic: unsigned (default). Each product is PRODUCT_WIDTH bits; the K-term sum is zero-extended to SUM_WIDTH, so there is no overflow.
- Outputs:
  - dataOut lane r = s[r] when sv[r]=1, otherwise 0.
  - dataOut_done = OR of sv[0..K-1].
- Latency: a vector sampled at edge t appears on lane r after edge t+1+r.
  - One isolated vector therefore gives K consecutive dataOut_done cycles.
  - N back-to-back vectors give N+K-1 consecutive done cycles.
- en=0 inserts a bubble that travels down the chain. The pipeline never stalls; in-flight results drain regardless of en.
- Simultaneous accept and drain is normal streaming; there is no backpressure.
- Reset asserted mid-stream: all in-flight results are discarded immediately, and weights must be reloaded (K cycles) before new data is accepted.

Optional Feature:
- Macro PE_SIGNED_ARITH_EN.
- Defined: data and weights are two's complement; products and sums are sign-extended to SUM_WIDTH, and dataOut lanes are signed.
- Undefined: unsigned arithmetic as above.

Test Plan:
- Reset/load: hold rstn=0 for 5 cycles, then release with weightsIn constant -> ready=0, dataOut=0, dataOut_done=0 for K=3 edges, then ready=1 and stays high.
- Single vector: weights W[r][c]=r+1; after ready, apply en=1 with dataIn=[0,1,2] for one cycle -> lane0=3 one edge later, lane1=6 the next edge, lane2=9 the edge after; done high exactly 3 cycles.
- Stream: same weights, dataIn=[i,i+1,i+2] for i=0..4 on consecutive cycles -> lane r shows (r+1)*(3i+3): lane0 = 3,6,9,12,15; lane2 = 9,18,27,36,45; done high for 7 consecutive cycles.
- Bubble and early data:
  - en toggles 1,0,1 -> a zero lane with no done contribution between the two results.
  - en=1 before ready -> nothing captured, done stays 0.
- Width: all weights=255, dataIn=[255,255,255] -> each lane = 195075 (fits SUM_WIDTH=19); with PE_SIGNED_ARITH_EN, all -1 gives each lane = 3.
- Mid-stream reset: assert rstn=0 while done=1 -> dataOut=0, done=0, ready=0 immediately; after release, ready returns after 3 cycles.

Source files
------------

// File: rtl/pe_array_wrapper.sv
// Weight-stationary KxK MAC array: loads one weight row per cycle, then streams skewed row dot-products.
// Optional PE_SIGNED_ARITH_EN selects two's-complement data, weights and results.
module pe_array_wrapper #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             en,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]                dataIn,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]  weightsIn,
    output logic [(DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE)*KERNEL_SIZE-1:0] dataOut,
    output logic                                             dataOut_done,
    output logic                                             ready
);
    localparam int K             = KERNEL_SIZE;
    localparam int PRODUCT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int SUM_WIDTH     = PRODUCT_WIDTH + KERNEL_SIZE;
    localparam int CNT_W         = (K > 1) ? $clog2(K) : 1;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        r_cnt;
    logic [WEIGHT_WIDTH-1:0] w_q [K][K];
    logic [DATA_WIDTH-1:0]   d_q [K][K];
    logic [K-1:0]            v_q;
    logic [SUM_WIDTH-1:0]    s_q [K];
    logic [K-1:0]            sv_q;
    logic [SUM_WIDTH-1:0]    mac [K];

    // Operands are widened to SUM_WIDTH before multiplying, so the low bits are exact in both modes.
    function automatic logic [SUM_WIDTH-1:0] ext_w(input logic [WEIGHT_WIDTH-1:0] x);
`ifdef PE_SIGNED_ARITH_EN
        return {{(SUM_WIDTH-WEIGHT_WIDTH){x[WEIGHT_WIDTH-1]}}, x};
`else
        return {{(SUM_WIDTH-WEIGHT_WIDTH){1'b0}}, x};
`endif
    endfunction

    function automatic logic [SUM_WIDTH-1:0] ext_d(input logic [DATA_WIDTH-1:0] x);
`ifdef PE_SIGNED_ARITH_EN
        return {{(SUM_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
`else
        return {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, x};
`endif
    endfunction

    assign ready = (state == ST_RUN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_LOAD;
            r_cnt <= '0;
            for (int unsigned r = 0; r < K; r++)
                for (int unsigned c = 0; c < K; c++)
                    w_q[r][c] <= '0;
        end else if (state == ST_LOAD) begin
            for (int unsigned c = 0; c < K; c++)
                w_q[r_cnt][c] <= weightsIn[(int'(r_cnt)*K + int'(c))*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            if (r_cnt == CNT_W'(K-1)) begin
                state <= ST_RUN;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q  <= '0;
            sv_q <= '0;
            for (int unsigned r = 0; r < K; r++) begin
                s_q[r] <= '0;
                for (int unsigned c = 0; c < K; c++)
                    d_q[r][c] <= '0;
            end
        end else begin
            v_q[0] <= en & ready;
            for (int unsigned c = 0; c < K; c++)
                d_q[0][c] <= dataIn[c*DATA_WIDTH +: DATA_WIDTH];
            for (int unsigned r = 1; r < K; r++) begin
                v_q[r] <= v_q[r-1];
                for (int unsigned c = 0; c < K; c++)
                    d_q[r][c] <= d_q[r-1][c];
            end
            for (int unsigned r = 0; r < K; r++)
                s_q[r] <= mac[r];
            sv_q <= v_q;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            mac[r] = '0;
            for (int unsigned c = 0; c < K; c++)
                mac[r] = mac[r] + ext_w(w_q[r][c]) * ext_d(d_q[r][c]);
        end
    end

    always_comb begin
        dataOut = '0;
        for (int unsigned r = 0; r < K; r++)
            dataOut[r*SUM_WIDTH +: SUM_WIDTH] = sv_q[r] ? s_q[r] : '0;
    end

    assign dataOut_done = |sv_q;

endmodule

// File: tb/tb_pe_array_wrapper.sv
// Directed bench for pe_array_wrapper (K=3, 8-bit data/weights, 19-bit lanes).
module tb_pe_array_wrapper;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [23:0] dataIn = '0;
    logic [71:0] weightsIn = '0;
    logic [56:0] dataOut;
    logic        dataOut_done;
    logic        ready;

    int vectors = 0;
    int miscompares = 0;

    pe_array_wrapper #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .WEIGHT_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .en(en), .dataIn(dataIn), .weightsIn(weightsIn),
        .dataOut(dataOut), .dataOut_done(dataOut_done), .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [56:0] pack3(input int unsigned a, input int unsigned b, input int unsigned c);
        return {19'(c), 19'(b), 19'(a)};
    endfunction

    function automatic logic [23:0] vec3(input int unsigned a, input int unsigned b, input int unsigned c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    // Row r of every weight row set to row_val[r].
    function automatic logic [71:0] wrows(input int unsigned r0, input int unsigned r1, input int unsigned r2);
        logic [71:0] w;
        int unsigned rv [3];
        rv[0] = r0; rv[1] = r1; rv[2] = r2;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'(rv[r]);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_load(input logic [71:0] w);
        en = 1'b0;
        rstn = 1'b0;
        weightsIn = w;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en = 1'b0;
        weightsIn = wrows(1, 2, 3);
        repeat (5) tick();
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %0b want 0", ready); end
        vectors++;
        if (dataOut_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", dataOut_done); end
        vectors++;
        if (dataOut !== '0) begin miscompares++; $display("FAIL reset_dataOut got %h want 0", dataOut); end
        rstn = 1'b1;
        en = 1'b1;
        dataIn = vec3(1, 1, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (ready !== (k == 3)) begin miscompares++; $display("FAIL load_ready edge %0d got %0b want %0b", k, ready, (k == 3)); end
            vectors++;
            if (dataOut_done !== 1'b0 || dataOut !== '0) begin
                miscompares++; $display("FAIL load_quiet edge %0d done %0b data %h want 0/0", k, dataOut_done, dataOut);
            end
        end
        en = 1'b0;
        weightsIn = wrows(9, 9, 9);
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (dataOut_done !== 1'b0 || ready !== 1'b1) begin
                miscompares++; $display("FAIL early_en step %0d done %0b ready %0b want 0/1", k, dataOut_done, ready);
            end
        end
    endtask

    task automatic test_single();
        logic [56:0] exp_out [5];
        exp_out[0] = '0; exp_out[1] = pack3(3, 0, 0); exp_out[2] = pack3(0, 6, 0);
        exp_out[3] = pack3(0, 0, 9); exp_out[4] = '0;
        en = 1'b1;
        dataIn = vec3(0, 1, 2);
        for (int k = 0; k < 5; k++) begin
            tick();
            en = 1'b0;
            vectors++;
            if (dataOut !== exp_out[k] || dataOut_done !== (k >= 1 && k <= 3)) begin
                miscompares++;
                $display("FAIL single edge %0d got %h/%0b want %h/%0b", k, dataOut, dataOut_done, exp_out[k], (k >= 1 && k <= 3));
            end
        end
    endtask

    task automatic test_stream();
        int done_cnt = 0;
        logic [56:0] exp_out;
        for (int k = 0; k < 9; k++) begin
            if (k < 5) begin
                en = 1'b1;
                dataIn = vec3(k, k + 1, k + 2);
            end else begin
                en = 1'b0;
            end
            tick();
            exp_out = '0;
            for (int r = 0; r < 3; r++) begin
                int i;
                i = k - 1 - r;
                if (i >= 0 && i < 5) exp_out[r*19 +: 19] = 19'((r + 1) * (3 * i + 3));
            end
            if (dataOut_done === 1'b1) done_cnt++;
            vectors++;
            if (dataOut !== exp_out) begin
                miscompares++; $display("FAIL stream edge %0d got %h want %h", k, dataOut, exp_out);
            end
        end
        en = 1'b0;
        vectors++;
        if (done_cnt != 7) begin miscompares++; $display("FAIL stream_done_cycles got %0d want 7", done_cnt); end
    endtask

    task automatic test_bubble();
        logic [56:0] exp_out [7];
        logic        exp_done [7];
        exp_out[0] = '0;               exp_done[0] = 1'b0;
        exp_out[1] = pack3(3, 0, 0);   exp_done[1] = 1'b1;
        exp_out[2] = pack3(0, 6, 0);   exp_done[2] = 1'b1;
        exp_out[3] = pack3(6, 0, 9);   exp_done[3] = 1'b1;
        exp_out[4] = pack3(0, 12, 0);  exp_done[4] = 1'b1;
        exp_out[5] = pack3(0, 0, 18);  exp_done[5] = 1'b1;
        exp_out[6] = '0;               exp_done[6] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            en = (k == 0 || k == 2);
            dataIn = (k == 0) ? vec3(1, 1, 1) : vec3(2, 2, 2);
            tick();
            vectors++;
            if (dataOut !== exp_out[k] || dataOut_done !== exp_done[k]) begin
                miscompares++;
                $display("FAIL bubble edge %0d got %h/%0b want %h/%0b", k, dataOut, dataOut_done, exp_out[k], exp_done[k]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_width();
        int unsigned lane;
`ifdef PE_SIGNED_ARITH_EN
        lane = 3;
`else
        lane = 195075;
`endif
        reset_and_load(wrows(255, 255, 255));
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL width_ready got %0b want 1", ready); end
        en = 1'b1;
        dataIn = vec3(255, 255, 255);
        tick();
        en = 1'b0;
        for (int r = 0; r < 3; r++) begin
            logic [56:0] e;
            tick();
            e = '0;
            e[r*19 +: 19] = 19'(lane);
            vectors++;
            if (dataOut !== e) begin miscompares++; $display("FAIL width lane %0d got %h want %h", r, dataOut, e); end
        end
    endtask

    task automatic test_midreset();
        reset_and_load(wrows(1, 2, 3));
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dataIn = vec3(k, k + 1, k + 2);
            tick();
        end
        vectors++;
        if (dataOut_done !== 1'b1) begin miscompares++; $display("FAIL midreset_pre_done got %0b want 1", dataOut_done); end
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (dataOut !== '0 || dataOut_done !== 1'b0 || ready !== 1'b0) begin
            miscompares++; $display("FAIL midreset_async got %h/%0b/%0b want 0/0/0", dataOut, dataOut_done, ready);
        end
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (ready !== (k == 3) || dataOut_done !== 1'b0) begin
                miscompares++; $display("FAIL midreset_reload edge %0d ready %0b done %0b want %0b/0", k, ready, dataOut_done, (k == 3));
            end
        end
        dataIn = vec3(1, 0, 0);
        tick();
        en = 1'b0;
        tick();
        vectors++;
        if (dataOut !== pack3(1, 0, 0)) begin miscompares++; $display("FAIL midreset_after got %h want %h", dataOut, pack3(1, 0, 0)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_bubble();
        test_width();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
